// File: rtl/waveform_capture_scheduler_pkg.sv
// Shared types and width helpers for the waveform capture scheduler.
package capture_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    SEND = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam int OVR_W = 16;

  // Column index width; a single-column build still gets a 1-bit index.
  function automatic int col_width(input int columns);
    return (columns > 1) ? $clog2(columns) : 1;
  endfunction

  // Row counter must be able to hold ROWS itself.
  function automatic int row_width(input int rows);
    return $clog2(rows + 1);
  endfunction

  function automatic int div_width(input int clk_div);
    return (clk_div > 1) ? $clog2(clk_div) : 1;
  endfunction

endpackage

// File: rtl/waveform_capture_scheduler_if.sv
// Word stream from the scheduler to the logging sink (valid/ready).
interface waveform_capture_scheduler_if #(
  parameter int BITS    = 16,
  parameter int COLUMNS = 2
);
  localparam int COL_W = capture_pkg::col_width(COLUMNS);

  logic [BITS-1:0]  out_data;
  logic [COL_W-1:0] out_col;
  logic             out_last;
  logic             out_valid;
  logic             out_ready;

  modport master (output out_data, out_col, out_last, out_valid, input out_ready);
  modport slave  (input out_data, out_col, out_last, out_valid, output out_ready);
endinterface

// File: rtl/waveform_capture_scheduler_strobe.sv
// Sample-rate divider: one-cycle strobe every CLK_DIV system clocks.
module sample_strobe_gen #(
  parameter int CLK_DIV = 1000
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic strobe
);
  localparam int DIV_W = capture_pkg::div_width(CLK_DIV);
  localparam logic [DIV_W-1:0] LAST = DIV_W'(CLK_DIV - 1);

  logic [DIV_W-1:0] cnt;

  // Free-running wrap counter, held when disabled, zeroed on clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)               cnt <= '0;
    else if (clear)        cnt <= '0;
    else if (enable)       cnt <= (cnt == LAST) ? '0 : cnt + DIV_W'(1);
  end

  assign strobe = (cnt == LAST);
endmodule

// File: rtl/waveform_capture_scheduler.sv
// Capture scheduler: latches a row of channel words per sample strobe and
// serializes it to the sink; counts delivered rows and rows lost to backpressure.
module waveform_capture_scheduler
  import capture_pkg::*;
#(
  parameter int CLK_DIV = 1000,
  parameter int BITS    = 16,
  parameter int COLUMNS = 2,
  parameter int ROWS    = 64000
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic                          abort,
  input  logic [BITS*COLUMNS-1:0]       data,
  waveform_capture_scheduler_if.master  sink,
  output logic                          busy,
  output logic                          done,
  output logic [row_width(ROWS)-1:0]    row_count,
  output logic [OVR_W-1:0]              overrun_count
);
  localparam int COL_W = col_width(COLUMNS);
  localparam int ROW_W = row_width(ROWS);
  localparam logic [COL_W-1:0] LAST_COL = COL_W'(COLUMNS - 1);
  localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(ROWS - 1);

  state_t state, state_nxt;
  logic [COLUMNS-1:0][BITS-1:0] row_reg;
  logic [COL_W-1:0] col;
  logic strobe, div_en;
  logic handshake, final_hs;
  logic load_row, inc_col, inc_row, inc_ovr, clr_cnts;

  assign div_en    = (state == WAIT) || (state == SEND);
  assign handshake = (state == SEND) && sink.out_ready;
  assign final_hs  = handshake && (col == LAST_COL);

  sample_strobe_gen #(.CLK_DIV(CLK_DIV)) u_strobe (
    .clk    (clk),
    .rst    (rst),
    .clear  (clr_cnts),
    .enable (div_en),
    .strobe (strobe)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next state and datapath controls; abort outranks start and handshakes.
  always_comb begin
    state_nxt = state;
    load_row  = 1'b0;
    inc_col   = 1'b0;
    inc_row   = 1'b0;
    inc_ovr   = 1'b0;
    clr_cnts  = 1'b0;
    case (state)
      IDLE, DONE: begin
        if (abort) state_nxt = IDLE;
        else if (start) begin
          state_nxt = WAIT;
          clr_cnts  = 1'b1;
        end
      end
      WAIT: begin
        if (abort) state_nxt = IDLE;
        else if (strobe) begin
          load_row  = 1'b1;
          state_nxt = SEND;
        end
      end
      SEND: begin
        if (abort) state_nxt = IDLE;
        else begin
          if (handshake && !final_hs) inc_col = 1'b1;
          if (final_hs) begin
            inc_row = 1'b1;
            // A strobe on the closing beat of the final row is dropped, not an overrun.
            if (row_count == LAST_ROW) state_nxt = DONE;
            else if (strobe)           load_row  = 1'b1;
            else                       state_nxt = WAIT;
          end else if (strobe) begin
            inc_ovr = 1'b1;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Row buffer, column pointer and run counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      row_reg       <= '0;
      col           <= '0;
      row_count     <= '0;
      overrun_count <= '0;
    end else begin
      if (clr_cnts) begin
        col           <= '0;
        row_count     <= '0;
        overrun_count <= '0;
      end
      if (load_row) begin
        row_reg <= data;
        col     <= '0;
      end else if (inc_col) begin
        col <= col + COL_W'(1);
      end
      if (inc_row) row_count <= row_count + ROW_W'(1);
      if (inc_ovr && (overrun_count != '1)) overrun_count <= overrun_count + OVR_W'(1);
    end
  end

  assign busy           = (state == WAIT) || (state == SEND);
  assign done           = (state == DONE);
  assign sink.out_valid = (state == SEND);
  assign sink.out_data  = (state == SEND) ? row_reg[col] : '0;
  assign sink.out_col   = (state == SEND) ? col : '0;
  assign sink.out_last  = (state == SEND) && (col == LAST_COL);
endmodule

// File: tb/tb_waveform_capture_scheduler.sv
// Self-checking bench for waveform_capture_scheduler (CLK_DIV=8, COLUMNS=2, ROWS=3).
module tb_waveform_capture_scheduler;
  localparam int CLK_DIV = 8;
  localparam int BITS    = 16;
  localparam int COLUMNS = 2;
  localparam int ROWS    = 3;

  logic        clk = 1'b0;
  logic        rst, start, abort;
  logic [31:0] data;
  logic        busy, done;
  logic [1:0]  row_count;
  logic [15:0] overrun_count;

  waveform_capture_scheduler_if #(.BITS(BITS), .COLUMNS(COLUMNS)) sink_if ();

  waveform_capture_scheduler #(
    .CLK_DIV(CLK_DIV), .BITS(BITS), .COLUMNS(COLUMNS), .ROWS(ROWS)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .abort         (abort),
    .data          (data),
    .sink          (sink_if),
    .busy          (busy),
    .done          (done),
    .row_count     (row_count),
    .overrun_count (overrun_count)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Reference model: run flags, edges since start, the current row and beat.
  bit          m_active, m_done, m_sending;
  int          m_since, m_beat, m_rows, m_ovr;
  logic [15:0] m_row [2];

  task automatic model_clear();
    m_active = 0; m_done = 0; m_sending = 0;
    m_since = 0; m_beat = 0; m_rows = 0; m_ovr = 0;
    m_row[0] = '0; m_row[1] = '0;
  endtask

  task automatic model_step();
    bit strobe, pre_send, hs, fin;
    strobe   = m_active && ((m_since % CLK_DIV) == CLK_DIV - 1);
    pre_send = m_sending;
    hs       = pre_send && sink_if.out_ready;
    fin      = hs && (m_beat == COLUMNS - 1);
    if (abort) begin
      if (m_active || m_done) begin
        m_active = 0; m_done = 0; m_sending = 0;
      end
    end else if (!m_active) begin
      if (start) begin
        m_active = 1; m_done = 0; m_sending = 0;
        m_since = 0; m_rows = 0; m_ovr = 0; m_beat = 0;
      end
    end else begin
      if (hs) begin
        if (!fin) m_beat++;
        else begin
          m_rows++;
          if (m_rows == ROWS) begin
            m_active = 0; m_done = 1; m_sending = 0;
          end else if (strobe) begin
            m_row[0] = data[15:0]; m_row[1] = data[31:16]; m_beat = 0;
          end else m_sending = 0;
        end
      end
      if (strobe && !pre_send) begin
        m_row[0] = data[15:0]; m_row[1] = data[31:16]; m_beat = 0; m_sending = 1;
      end
      if (strobe && pre_send && !fin && m_ovr != 16'hffff) m_ovr++;
      m_since++;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    if (!rst) model_step();
    #1;
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    while (!sink_if.out_valid && n < 40) begin
      tick();
      n++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b0; start = 1'b0; abort = 1'b0; data = '0; sink_if.out_ready = 1'b0;
    #2 rst = 1'b1;
    model_clear();
    #10;
    vectors++;
    if ({sink_if.out_valid, busy, done, row_count, overrun_count, sink_if.out_data} !== '0) begin
      miscompares++;
      $display("FAIL reset_outputs: got v=%b b=%b d=%b rc=%0d ov=%0d od=%h expected all 0",
               sink_if.out_valid, busy, done, row_count, overrun_count, sink_if.out_data);
    end
    @(negedge clk) rst = 1'b0;
    repeat (3) tick();
    vectors++;
    if (busy !== 1'b0 || sink_if.out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_idle: got busy=%b valid=%b expected 0 0", busy, sink_if.out_valid);
    end
  endtask

  task automatic test_basic();
    int n;
    logic [17:0] beats[$];
    data = 32'h0002_0001; sink_if.out_ready = 1'b1;
    start = 1'b1; tick(); start = 1'b0;
    wait_valid(n);
    vectors++;
    if (n != CLK_DIV) begin
      miscompares++;
      $display("FAIL basic_latency: got %0d cycles expected %0d", n, CLK_DIV);
    end
    for (int k = 0; k < 40; k++) begin
      if (sink_if.out_valid && sink_if.out_ready)
        beats.push_back({sink_if.out_col, sink_if.out_last, sink_if.out_data});
      if (done) break;
      tick();
    end
    vectors++;
    if (beats.size() != 6) begin
      miscompares++;
      $display("FAIL basic_beat_count: got %0d expected 6", beats.size());
    end
    for (int i = 0; i < beats.size() && i < 6; i++) begin
      vectors++;
      if (beats[i] !== {(i % 2 == 1), (i % 2 == 1), 16'((i % 2) + 1)}) begin
        miscompares++;
        $display("FAIL basic_beat%0d: got %h expected %h", i, beats[i],
                 {(i % 2 == 1), (i % 2 == 1), 16'((i % 2) + 1)});
      end
    end
    vectors++;
    if (done !== 1'b1 || row_count !== 2'd3 || overrun_count !== 16'd0 || sink_if.out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL basic_done: got done=%b rc=%0d ov=%0d v=%b expected 1 3 0 0",
               done, row_count, overrun_count, sink_if.out_valid);
    end
  endtask

  task automatic test_backpressure();
    int n;
    data = 32'h0002_0001; sink_if.out_ready = 1'b0;
    start = 1'b1; tick(); start = 1'b0;
    vectors++;
    if (done !== 1'b0 || busy !== 1'b1) begin
      miscompares++;
      $display("FAIL restart_from_done: got done=%b busy=%b expected 0 1", done, busy);
    end
    wait_valid(n);
    vectors++;
    if (n != CLK_DIV) begin
      miscompares++;
      $display("FAIL bp_latency: got %0d expected %0d", n, CLK_DIV);
    end
    for (int k = 0; k < 20; k++) begin
      tick();
      vectors++;
      if (sink_if.out_data !== 16'h0001 || sink_if.out_col !== 1'b0 || sink_if.out_valid !== 1'b1) begin
        miscompares++;
        $display("FAIL bp_hold%0d: got data=%h col=%b v=%b expected 0001 0 1",
                 k, sink_if.out_data, sink_if.out_col, sink_if.out_valid);
      end
    end
    vectors++;
    if (overrun_count !== 16'd2) begin
      miscompares++;
      $display("FAIL bp_overrun: got %0d expected 2", overrun_count);
    end
    sink_if.out_ready = 1'b1; tick();
    vectors++;
    if (sink_if.out_col !== 1'b1 || sink_if.out_data !== 16'h0002) begin
      miscompares++;
      $display("FAIL bp_resume: got col=%b data=%h expected 1 0002", sink_if.out_col, sink_if.out_data);
    end
    sink_if.out_ready = 1'b0; abort = 1'b1; tick(); abort = 1'b0;
    vectors++;
    if (sink_if.out_valid !== 1'b0 || busy !== 1'b0 || overrun_count !== 16'd2 || row_count !== 2'd0) begin
      miscompares++;
      $display("FAIL bp_abort_retain: got v=%b b=%b ov=%0d rc=%0d expected 0 0 2 0",
               sink_if.out_valid, busy, overrun_count, row_count);
    end
  endtask

  task automatic test_strobe_coincident();
    int n;
    data = 32'h0002_0001; sink_if.out_ready = 1'b0;
    start = 1'b1; tick(); start = 1'b0;
    wait_valid(n);
    data = 32'h0004_0003;
    sink_if.out_ready = 1'b1; tick();
    sink_if.out_ready = 1'b0;
    repeat (CLK_DIV - 2) tick();
    vectors++;
    if (sink_if.out_col !== 1'b1 || sink_if.out_data !== 16'h0002) begin
      miscompares++;
      $display("FAIL coinc_pre: got col=%b data=%h expected 1 0002", sink_if.out_col, sink_if.out_data);
    end
    sink_if.out_ready = 1'b1; tick();
    sink_if.out_ready = 1'b0;
    vectors++;
    if (sink_if.out_valid !== 1'b1 || sink_if.out_data !== 16'h0003 || sink_if.out_col !== 1'b0 ||
        overrun_count !== 16'd0 || row_count !== 2'd1) begin
      miscompares++;
      $display("FAIL coinc_newrow: got v=%b data=%h col=%b ov=%0d rc=%0d expected 1 0003 0 0 1",
               sink_if.out_valid, sink_if.out_data, sink_if.out_col, overrun_count, row_count);
    end
    abort = 1'b1; tick(); abort = 1'b0;
  endtask

  task automatic test_abort();
    int n;
    data = 32'h0002_0001; sink_if.out_ready = 1'b1;
    start = 1'b1; tick(); start = 1'b0;
    wait_valid(n);
    tick(); tick();
    wait_valid(n);
    vectors++;
    if (n != CLK_DIV - 2) begin
      miscompares++;
      $display("FAIL abort_row2_gap: got %0d expected %0d", n, CLK_DIV - 2);
    end
    tick();
    abort = 1'b1; tick(); abort = 1'b0;
    vectors++;
    if (sink_if.out_valid !== 1'b0 || busy !== 1'b0 || row_count !== 2'd1) begin
      miscompares++;
      $display("FAIL abort_midrow: got v=%b b=%b rc=%0d expected 0 0 1",
               sink_if.out_valid, busy, row_count);
    end
    start = 1'b1; tick(); start = 1'b0;
    vectors++;
    if (row_count !== 2'd0 || overrun_count !== 16'd0 || busy !== 1'b1) begin
      miscompares++;
      $display("FAIL abort_restart_clear: got rc=%0d ov=%0d b=%b expected 0 0 1",
               row_count, overrun_count, busy);
    end
    wait_valid(n);
    vectors++;
    if (n != CLK_DIV) begin
      miscompares++;
      $display("FAIL abort_restart_latency: got %0d expected %0d", n, CLK_DIV);
    end
  endtask

  task automatic test_async_reset();
    sink_if.out_ready = 1'b0;
    repeat (9) tick();
    vectors++;
    if (overrun_count !== 16'd1 || sink_if.out_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL arst_pre: got ov=%0d v=%b expected 1 1", overrun_count, sink_if.out_valid);
    end
    #2 rst = 1'b1;
    model_clear();
    #1;
    vectors++;
    if ({sink_if.out_valid, busy, done, row_count, overrun_count} !== '0) begin
      miscompares++;
      $display("FAIL arst_immediate: got v=%b b=%b d=%b rc=%0d ov=%0d expected all 0",
               sink_if.out_valid, busy, done, row_count, overrun_count);
    end
    #3 rst = 1'b0;
    repeat (12) tick();
    vectors++;
    if (busy !== 1'b0 || sink_if.out_valid !== 1'b0 || done !== 1'b0) begin
      miscompares++;
      $display("FAIL arst_idle: got b=%b v=%b d=%b expected 0 0 0", busy, sink_if.out_valid, done);
    end
  endtask

  task automatic test_start_while_busy();
    int n;
    data = 32'h0002_0001; sink_if.out_ready = 1'b1;
    start = 1'b1; tick(); start = 1'b0;
    wait_valid(n);
    tick();
    start = 1'b1; tick(); start = 1'b0;
    wait_valid(n);
    vectors++;
    if (n != CLK_DIV - 2) begin
      miscompares++;
      $display("FAIL busy_start_ignored: got %0d cycles to next row expected %0d", n, CLK_DIV - 2);
    end
    for (int k = 0; k < 40 && !done; k++) tick();
    vectors++;
    if (done !== 1'b1 || row_count !== 2'd3) begin
      miscompares++;
      $display("FAIL busy_run_done: got d=%b rc=%0d expected 1 3", done, row_count);
    end
    start = 1'b1; tick(); start = 1'b0;
    vectors++;
    if (done !== 1'b0 || busy !== 1'b1 || row_count !== 2'd0) begin
      miscompares++;
      $display("FAIL done_restart: got d=%b b=%b rc=%0d expected 0 1 0", done, busy, row_count);
    end
  endtask

  task automatic test_random();
    logic [38:0] got, exp;
    for (int k = 0; k < 1500; k++) begin
      data              = $urandom;
      sink_if.out_ready = ($urandom_range(0, 9) < 6);
      start             = ($urandom_range(0, 39) == 0);
      abort             = ($urandom_range(0, 119) == 0);
      tick();
      start = 1'b0; abort = 1'b0;
      got = {sink_if.out_valid, sink_if.out_data, sink_if.out_col, sink_if.out_last,
             busy, done, row_count, overrun_count};
      exp = {m_sending, m_sending ? m_row[m_beat] : 16'h0000, m_sending && (m_beat == 1),
             m_sending && (m_beat == COLUMNS - 1), m_active, m_done, m_rows[1:0], m_ovr[15:0]};
      vectors++;
      if (got !== exp) begin
        miscompares++;
        $display("FAIL random_cycle%0d: got %h expected %h", k, got, exp);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_strobe_coincident();
    test_abort();
    test_async_reset();
    test_start_while_busy();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
